// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT window, one-shot or
// auto-reload, registered interrupt line for HWInt[0].
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic        en, en_nx;
    logic        im, im_nx;
    logic [1:0]  mode, mode_nx;
    logic        flag, flag_nx;
    logic [31:0] preset, preset_nx;
    logic [31:0] count, count_nx;

    logic in_win;
    logic ctrl_wr;
    logic preset_wr;
    logic ctrl_b0;
    logic unused_bits;

    assign in_win    = addr[31:4] == BASE_ADDR[31:4];
    assign ctrl_wr   = we && in_win && addr[3:2] == 2'b00;
    assign preset_wr = we && in_win && addr[3:2] == 2'b01;
    assign ctrl_b0   = ctrl_wr && byteen[0];
    assign unused_bits = &{1'b0, addr[1:0]};

    always_comb begin
        rdata = '0;
        if (in_win) begin
            case (addr[3:2])
                2'b00:   rdata = {28'd0, im, mode, en};
                2'b01:   rdata = preset;
                2'b10:   rdata = count;
                default: rdata = '0;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        en_nx     = en;
        im_nx     = im;
        mode_nx   = mode;
        flag_nx   = flag;
        preset_nx = preset;
        count_nx  = count;

        if (ctrl_b0) begin
            en_nx   = wdata[0];
            mode_nx = (wdata[2:1] == 2'b01) ? 2'b01 : 2'b00;
            im_nx   = wdata[3];
        end
        for (int i = 0; i < 4; i++) begin
            if (preset_wr && byteen[i]) begin
                preset_nx[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        // A CTRL write acknowledges the flag, except one that unmasks it.
        if (ctrl_wr && !(ctrl_b0 && wdata[3] && !im)) begin
            flag_nx = 1'b0;
        end

        case (state)
            IDLE: begin
                if (en_nx) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                count_nx = preset;
                state_nx = CNT;
            end
            CNT: begin
                if (!en_nx) begin
                    state_nx = IDLE;
                end else if (count > 32'd1) begin
                    count_nx = count - 32'd1;
                end else begin
                    count_nx = '0;
                    flag_nx  = 1'b1;
                    state_nx = INT;
                end
            end
            INT: begin
                if (mode == 2'b01) begin
                    flag_nx  = 1'b0;
                    state_nx = LOAD;
                end else begin
                    en_nx    = ctrl_b0 && wdata[0];
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            en     <= 1'b0;
            im     <= 1'b0;
            mode   <= 2'b00;
            flag   <= 1'b0;
            preset <= '0;
            count  <= '0;
            irq    <= 1'b0;
        end else begin
            state  <= state_nx;
            en     <= en_nx;
            im     <= im_nx;
            mode   <= mode_nx;
            flag   <= flag_nx;
            preset <= preset_nx;
            count  <= count_nx;
            irq    <= im_nx & flag_nx;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: vector table, directed timing sequences and
// randomized bus traffic against a cycle-count based reference model.
module tb_mmio_timer;

    localparam logic [31:0] B = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  byteen = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    always #5 clk = ~clk;

    mmio_timer dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we),
        .byteen(byteen), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    // Model: a running countdown is described by the value loaded and the
    // edge it was loaded on; the live count is derived from elapsed edges.
    typedef enum {M_IDLE, M_ARMED, M_RUN, M_FIRED} mphase_t;
    mphase_t     ph;
    bit          m_en, m_ar, m_im, m_flag, m_irq;
    logic [31:0] m_preset, m_hold, m_p;
    longint      edges = 0;
    longint      t0 = 0;

    function automatic logic [31:0] m_count();
        if (ph == M_RUN) return m_p - 32'(edges - t0);
        return m_hold;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:4] != B[31:4]) return '0;
        case (a[3:2])
            2'd0:    return {28'd0, m_im, 1'b0, m_ar, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count();
            default: return '0;
        endcase
    endfunction

    task automatic m_reset();
        ph = M_IDLE;
        m_en = 0; m_ar = 0; m_im = 0; m_flag = 0; m_irq = 0;
        m_preset = '0; m_hold = '0; m_p = '0; t0 = edges;
    endtask

    task automatic model_edge(input logic [31:0] a, input logic w,
                              input logic [3:0] b, input logic [31:0] d);
        bit win, cw, pw, en_w, ar_w, im_w, f;
        logic [31:0] pre_w, v;
        win = a[31:4] == B[31:4];
        cw = w && win && a[3:2] == 2'd0;
        pw = w && win && a[3:2] == 2'd1;
        en_w = m_en; ar_w = m_ar; im_w = m_im; pre_w = m_preset; f = m_flag;
        if (cw && b[0]) begin
            en_w = d[0]; ar_w = (d[2:1] == 2'b01); im_w = d[3];
        end
        if (pw)
            for (int k = 0; k < 4; k++)
                if (b[k]) pre_w[8*k +: 8] = d[8*k +: 8];
        if (cw && !(b[0] && d[3] && !m_im)) f = 0;
        v = m_count();
        edges++;
        case (ph)
            M_IDLE: if (en_w) ph = M_ARMED;
            M_ARMED: begin
                m_p = m_preset; t0 = edges; ph = M_RUN;
            end
            M_RUN: begin
                if (!en_w) begin
                    m_hold = v; ph = M_IDLE;
                end else if (v <= 32'd1) begin
                    m_hold = '0; f = 1; ph = M_FIRED;
                end
            end
            M_FIRED: begin
                if (m_ar) begin
                    f = 0; ph = M_ARMED;
                end else begin
                    en_w = cw && b[0] && d[0]; ph = M_IDLE;
                end
            end
        endcase
        m_en = en_w; m_ar = ar_w; m_im = im_w; m_preset = pre_w;
        m_flag = f; m_irq = im_w & f;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [31:0] a, input logic w,
                        input logic [3:0] b, input logic [31:0] d,
                        output logic [31:0] r, output logic i);
        @(negedge clk);
        addr = a; we = w; byteen = b; wdata = d;
        #1;
        r = rdata; i = irq;
        check("model rdata", r, m_read(a));
        check("model irq", {31'd0, i}, {31'd0, m_irq});
        @(posedge clk);
        model_edge(a, w, b, d);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d);
        logic [31:0] r;
        logic i;
        step(a, 1'b1, b, d, r, i);
    endtask

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] r;
    logic        i;

    initial begin
        tbl.push_back('{B + 32'h0, 1'b0, 4'h0, 32'h0, 32'h0});
        tbl.push_back('{B + 32'h4, 1'b0, 4'h0, 32'h0, 32'h0});
        tbl.push_back('{B + 32'h8, 1'b0, 4'h0, 32'h0, 32'h0});
        tbl.push_back('{B + 32'hC, 1'b0, 4'h0, 32'h0, 32'h0});
        tbl.push_back('{B + 32'h5, 1'b1, 4'h2, 32'h0000_AB00, 32'h0});
        tbl.push_back('{B + 32'h4, 1'b0, 4'h0, 32'h0, 32'h0000_AB00});
        tbl.push_back('{B + 32'h8, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{B + 32'h8, 1'b0, 4'h0, 32'h0, 32'h0});
        tbl.push_back('{B + 32'hC, 1'b1, 4'hF, 32'h1234_5678, 32'h0});
        tbl.push_back('{B + 32'hC, 1'b0, 4'h0, 32'h0, 32'h0});
        tbl.push_back('{B + 32'h0, 1'b1, 4'h1, 32'hFFFF_FFF6, 32'h0});
        tbl.push_back('{B + 32'h0, 1'b0, 4'h0, 32'h0, 32'h0});
        tbl.push_back('{B + 32'h6, 1'b1, 4'hC, 32'h1234_0000, 32'h0000_AB00});
        tbl.push_back('{B + 32'h4, 1'b0, 4'h0, 32'h0, 32'h1234_AB00});
        tbl.push_back('{B + 32'h84, 1'b1, 4'hF, 32'h0, 32'h0});
        tbl.push_back('{B + 32'h4, 1'b0, 4'h0, 32'h0, 32'h1234_AB00});
        tbl.push_back('{B + 32'h7, 1'b1, 4'hF, 32'h0, 32'h1234_AB00});
        tbl.push_back('{B + 32'h4, 1'b0, 4'h0, 32'h0, 32'h0});

        m_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset irq", {31'd0, irq}, 32'd0);
        reset = 1'b1;

        foreach (tbl[n]) begin
            step(tbl[n].a, tbl[n].w, tbl[n].be, tbl[n].d, r, i);
            check($sformatf("vec%0d rdata", n), r, tbl[n].exp);
            check($sformatf("vec%0d irq", n), {31'd0, i}, 32'd0);
        end

        // One-shot, PRESET=5
        wr(B + 4, 4'hF, 32'd5);
        wr(B, 4'hF, 32'h9);
        for (int j = 0; j <= 7; j++) begin
            step(B + 8, 1'b0, 4'h0, 32'h0, r, i);
            if (j >= 1 && j <= 6) check("oneshot count", r, 32'(6 - j));
            check("oneshot irq", {31'd0, i}, {31'd0, j >= 6});
        end
        step(B, 1'b0, 4'h0, 32'h0, r, i);
        check("oneshot ctrl", r, 32'h8);
        wr(B, 4'hF, 32'h8);
        step(B, 1'b0, 4'h0, 32'h0, r, i);
        check("oneshot ack irq", {31'd0, i}, 32'd0);

        // Auto-reload, PRESET 3 then 10 written mid-count
        wr(B + 4, 4'hF, 32'd3);
        wr(B, 4'hF, 32'hB);
        for (int j = 0; j <= 40; j++) begin
            if (j == 11) step(B + 4, 1'b1, 4'hF, 32'd10, r, i);
            else         step(B + 8, 1'b0, 4'h0, 32'h0, r, i);
            check($sformatf("reload irq j%0d", j), {31'd0, i},
                  {31'd0, j == 4 || j == 9 || j == 14 || j == 26 || j == 38});
        end
        wr(B, 4'hF, 32'h0);

        // Disable on the terminal-count cycle
        wr(B + 4, 4'hF, 32'd4);
        wr(B, 4'hF, 32'h9);
        for (int j = 0; j <= 10; j++) begin
            if (j == 4) step(B, 1'b1, 4'hF, 32'h8, r, i);
            else        step(B + 8, 1'b0, 4'h0, 32'h0, r, i);
            if (j >= 1 && j <= 3) check("stop count", r, 32'(5 - j));
            if (j >= 5) check("stop held", r, 32'd1);
            check("stop irq", {31'd0, i}, 32'd0);
        end

        // Masked flag, unmasked later
        wr(B + 4, 4'hF, 32'd1);
        wr(B, 4'hF, 32'h1);
        for (int j = 0; j <= 3; j++) begin
            step(B + 8, 1'b0, 4'h0, 32'h0, r, i);
            check("masked irq", {31'd0, i}, 32'd0);
        end
        wr(B, 4'hF, 32'h8);
        step(B, 1'b0, 4'h0, 32'h0, r, i);
        check("unmask irq", {31'd0, i}, 32'd1);
        wr(B, 4'hF, 32'h8);
        step(B, 1'b0, 4'h0, 32'h0, r, i);
        check("unmask ack", {31'd0, i}, 32'd0);

        // Asynchronous reset mid-count
        wr(B + 4, 4'hF, 32'd3);
        wr(B, 4'hF, 32'h9);
        step(B + 8, 1'b0, 4'h0, 32'h0, r, i);
        step(B + 8, 1'b0, 4'h0, 32'h0, r, i);
        @(negedge clk);
        addr = B + 8; we = 1'b0; byteen = 4'h0;
        #1;
        check("pre-reset count", rdata, 32'd2);
        #1 reset = 1'b0;
        m_reset();
        #1;
        check("async count", rdata, 32'd0);
        check("async irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // PRESET=0 fires like PRESET=1, then reset drops a high irq
        wr(B, 4'hF, 32'h9);
        for (int j = 0; j <= 2; j++) begin
            step(B + 8, 1'b0, 4'h0, 32'h0, r, i);
            check("zero preset irq", {31'd0, i}, {31'd0, j == 2});
        end
        @(negedge clk);
        #1 reset = 1'b0;
        m_reset();
        #1;
        check("async irq drop", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, d;
            logic        w;
            logic [3:0]  b;
            if ($urandom_range(0, 15) == 0) a = $urandom;
            else a = B + 32'($urandom_range(0, 4)) * 4 + 32'($urandom_range(0, 3));
            w = ($urandom_range(0, 5) == 0);
            b = w ? 4'($urandom_range(1, 15)) : 4'($urandom);
            d = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 7));
            step(a, w, b, d, r, i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
